// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter for the single register file write port.
// Registers the winning write and keeps a per-register busy scoreboard.
//
// Ports:
//   clk, reset     - clock; asynchronous active-high reset
//   req_valid      - NUM_REQ pending-write flags
//   req_ready      - one-hot (or zero) grant, combinational
//   req_index      - packed DEPTH-bit destination per requester
//   req_data       - packed WIDTH-bit write data per requester
//   reserve_valid  - issue logic reserving reserve_index
//   reserve_index  - register being reserved
//   write_enable   - registered register file write enable
//   write_index    - registered register file write index
//   write_data     - registered register file write data
//   busy_mask      - bit r set while register r is reserved
`timescale 1ns/1ps
module writeback_arbiter #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 5,
    parameter int NUM_REQ = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*DEPTH-1:0] req_index,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic                     reserve_valid,
    input  logic [DEPTH-1:0]         reserve_index,
    output logic                     write_enable,
    output logic [DEPTH-1:0]         write_index,
    output logic [WIDTH-1:0]         write_data,
    output logic [2**DEPTH-1:0]      busy_mask
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]        ptr;
    logic [PW-1:0]        sel;
    logic                 any_grant;
    logic [DEPTH-1:0]     win_index;
    logic [WIDTH-1:0]     win_data;
    logic [2**DEPTH-1:0]  busy_next;

    // Requester number k positions after base, wrapped modulo NUM_REQ.
    function automatic logic [PW-1:0] slot(input logic [PW-1:0] base,
                                           input int k);
        int s;
        s = (int'(base) + k) % NUM_REQ;
        return PW'(s);
    endfunction

    // First valid requester at or after the pointer wins.
    always_comb begin
        any_grant = 1'b0;
        sel       = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_grant && req_valid[slot(ptr, k)]) begin
                any_grant = 1'b1;
                sel       = slot(ptr, k);
            end
        end
    end

    assign req_ready = any_grant ? (NUM_REQ'(1) << sel) : '0;
    assign win_index = req_index[int'(sel)*DEPTH +: DEPTH];
    assign win_data  = req_data[int'(sel)*WIDTH +: WIDTH];

    // Index 0 is the hardwired zero register: the grant is consumed
    // but nothing is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr          <= '0;
            write_enable <= 1'b0;
            write_index  <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= any_grant && (win_index != '0);
            if (any_grant) begin
                write_index <= win_index;
                write_data  <= win_data;
                ptr         <= slot(sel, 1);
            end
        end
    end

    // Clear applied before set so a fresh reservation of the register
    // being committed survives the commit.
    always_comb begin
        busy_next = busy_mask;
        if (write_enable && write_index != '0)
            busy_next[write_index] = 1'b0;
        if (reserve_valid && reserve_index != '0)
            busy_next[reserve_index] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy_mask <= '0;
        else
            busy_mask <= busy_next;
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed cases plus
// randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_index;
    logic [95:0] req_data;
    logic        reserve_valid;
    logic [4:0]  reserve_index;
    logic        write_enable;
    logic [4:0]  write_index;
    logic [31:0] write_data;
    logic [31:0] busy_mask;

    int total = 0;
    int bad = 0;

    int       m_ptr;
    bit       m_we;
    bit [4:0] m_widx;
    bit [31:0] m_wdata;
    bit [31:0] m_busy;
    int       last_g;
    int       dut_commits = 0;
    int       saved;

    logic [2:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100,
                               3'b001, 3'b010, 3'b100};

    writeback_arbiter #(.WIDTH(32), .DEPTH(5), .NUM_REQ(3)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_index(req_index),
        .req_data(req_data),
        .reserve_valid(reserve_valid),
        .reserve_index(reserve_index),
        .write_enable(write_enable),
        .write_index(write_index),
        .write_data(write_data),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    // Writes the register file actually captures.
    always @(posedge clk)
        if (write_enable)
            dut_commits <= dut_commits + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < 3; k++) begin
            int i = (m_ptr + k) % 3;
            if (req_valid[i])
                return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_we    = 0;
        m_widx  = 0;
        m_wdata = 0;
        m_busy  = 0;
    endtask

    // One clock: compare at the falling edge, advance model at rising.
    task automatic step();
        int g;
        @(negedge clk);
        g = model_grant();
        chk("ready", req_ready, (g < 0) ? 0 : (1 << g));
        chk("we", write_enable, m_we);
        chk("widx", write_index, m_widx);
        chk("wdata", write_data, m_wdata);
        chk("busy", busy_mask, m_busy);
        @(posedge clk);
        if (m_we && m_widx != 0)
            m_busy[m_widx] = 1'b0;
        if (reserve_valid && reserve_index != 0)
            m_busy[reserve_index] = 1'b1;
        if (g >= 0) begin
            m_widx  = req_index[g*5 +: 5];
            m_wdata = req_data[g*32 +: 32];
            m_we    = (m_widx != 0);
            m_ptr   = (g + 1) % 3;
        end else begin
            m_we = 1'b0;
        end
        last_g = g;
        #1;
    endtask

    task automatic do_reset();
        req_valid     = '0;
        reserve_valid = 1'b0;
        reset         = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = '0;
        req_index     = '0;
        req_data      = '0;
        reserve_valid = 1'b0;
        reserve_index = '0;
        do_reset();

        chk("rst_we", write_enable, 0);
        chk("rst_widx", write_index, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_busy", busy_mask, 0);

        // single request
        req_valid       = 3'b001;
        req_index[4:0]  = 5'd5;
        req_data[31:0]  = 32'h12345678;
        #1 chk("single_ready", req_ready, 3'b001);
        step();
        req_valid = '0;
        chk("single_we", write_enable, 1);
        chk("single_widx", write_index, 5);
        chk("single_wdata", write_data, 32'h12345678);
        step();
        chk("single_we_off", write_enable, 0);

        // round-robin fairness
        do_reset();
        req_valid = 3'b111;
        req_index = {5'd3, 5'd2, 5'd1};
        for (int c = 0; c < 6; c++) begin
            #1 chk("rr_grant", req_ready, rr_exp[c]);
            step();
            chk("rr_we", write_enable, 1);
        end
        req_valid = '0;
        step();

        // index 0 write
        do_reset();
        reserve_valid = 1'b1;
        reserve_index = 5'd3;
        step();
        reserve_valid  = 1'b0;
        req_valid      = 3'b010;
        req_index[9:5] = 5'd0;
        req_data[63:32] = 32'hFFFFFFFF;
        #1 chk("idx0_ready", req_ready, 3'b010);
        step();
        req_valid = '0;
        chk("idx0_we", write_enable, 0);
        chk("idx0_busy", busy_mask, 32'h8);
        req_valid = 3'b111;
        req_index = {5'd3, 5'd2, 5'd1};
        #1 chk("idx0_ptr", req_ready, 3'b100);
        step();
        req_valid = '0;
        step();

        // scoreboard lifecycle
        do_reset();
        reserve_valid = 1'b1;
        reserve_index = 5'd9;
        step();
        reserve_valid = 1'b0;
        chk("sb_set", busy_mask, 32'h200);
        step();
        chk("sb_hold", busy_mask, 32'h200);
        req_valid         = 3'b100;
        req_index[14:10]  = 5'd9;
        req_data[95:64]   = 32'hCAFE0009;
        step();
        req_valid = '0;
        chk("sb_we", write_enable, 1);
        chk("sb_widx", write_index, 9);
        chk("sb_pre_commit", busy_mask, 32'h200);
        step();
        chk("sb_cleared", busy_mask, 0);

        // simultaneous set and clear of the same index
        reserve_valid = 1'b1;
        reserve_index = 5'd9;
        step();
        reserve_valid = 1'b0;
        req_valid     = 3'b100;
        step();
        req_valid     = '0;
        reserve_valid = 1'b1;
        reserve_index = 5'd9;
        chk("sim_we", write_enable, 1);
        step();
        reserve_valid = 1'b0;
        chk("sim_busy", busy_mask, 32'h200);

        // reservation of index 0
        do_reset();
        reserve_valid = 1'b1;
        reserve_index = 5'd0;
        step();
        reserve_valid = 1'b0;
        chk("res0_busy", busy_mask, 0);

        // reset asserted mid-cycle with a write in flight
        do_reset();
        reserve_valid = 1'b1;
        reserve_index = 5'd7;
        step();
        reserve_valid  = 1'b0;
        req_valid      = 3'b001;
        req_index[4:0] = 5'd7;
        req_data[31:0] = 32'hDEADBEEF;
        step();
        req_valid = '0;
        chk("pre_rst_we", write_enable, 1);
        saved = dut_commits;
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_we", write_enable, 0);
        chk("mid_rst_busy", busy_mask, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        step();
        chk("rst_no_commit", dut_commits, saved);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_index[i*5 +: 5] = ($urandom_range(0, 3) == 0) ?
                        5'd0 : 5'($urandom_range(1, 12));
                    req_data[i*32 +: 32] = $urandom();
                end
            end
            reserve_valid = ($urandom_range(0, 2) == 0);
            reserve_index = 5'($urandom_range(0, 12));
            step();
            if (last_g >= 0)
                req_valid[last_g] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
